// File: rtl/wlo_quant_mult_pkg.sv
// -----------------------------------------------------------------------------
// wlo_pkg
// Shared types and constants for the word-length-optimisation multiplier.
//   round_mode_e : product/operand rounding mode (truncate or round-half-up)
//   wlo_cfg_t    : active quantisation configuration
//   default_cfg  : full-precision configuration applied at reset
//   clamp_u8     : clamps an 8-bit config field into [lo, hi]
// -----------------------------------------------------------------------------
package wlo_pkg;

  localparam int DEF_IN_W    = 14;
  localparam int DEF_IN_FRAC = 12;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic {
    TRUNC       = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_e;

  typedef struct packed {
    logic [7:0]  frac_a;
    logic [7:0]  frac_b;
    logic [7:0]  frac_c;
    logic [7:0]  int_c;
    round_mode_e round;
    logic        sat;
  } wlo_cfg_t;

  // Full precision: nothing is dropped, product keeps every integer bit.
  function automatic wlo_cfg_t default_cfg(input int in_frac, input int out_w,
                                           input int out_frac);
    wlo_cfg_t cfg;
    cfg.frac_a = 8'(in_frac);
    cfg.frac_b = 8'(in_frac);
    cfg.frac_c = 8'(out_frac);
    cfg.int_c  = 8'(out_w - out_frac);
    cfg.round  = TRUNC;
    cfg.sat    = 1'b0;
    return cfg;
  endfunction

  function automatic logic [7:0] clamp_u8(input logic [7:0] v, input logic [7:0] lo,
                                          input logic [7:0] hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/wlo_quant_mult_if.sv
// -----------------------------------------------------------------------------
// wlo_quant_mult_if
// Bundles the config, operand, product and statistics signals of one
// wlo_quant_mult instance.
//   config  : cfg_valid/cfg_ready + cfg_frac_a/b/c, cfg_int_c, cfg_round, cfg_sat
//   operand : in_valid/in_ready + a, b
//   product : out_valid/out_ready + c, c_ovf
//   stats   : ovf_cnt, cnt_clr
//
// Handshake rule for all three channels: a transfer happens on a rising clock
// edge where valid and ready are both high. Once raised, valid and its payload
// stay stable until that edge. ready may depend combinationally on valid
// (cfg_ready looks at in_valid), but valid never depends on ready.
// -----------------------------------------------------------------------------
interface wlo_quant_mult_if #(
  parameter int IN_W  = 14,
  parameter int OUT_W = 2 * IN_W + 1,
  parameter int CNT_W = 16
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [7:0]        cfg_frac_a;
  logic [7:0]        cfg_frac_b;
  logic [7:0]        cfg_frac_c;
  logic [7:0]        cfg_int_c;
  logic              cfg_round;
  logic              cfg_sat;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   a;
  logic [IN_W-1:0]   b;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  c;
  logic              c_ovf;
  logic [CNT_W-1:0]  ovf_cnt;
  logic              cnt_clr;

  modport master (
    output cfg_valid, cfg_frac_a, cfg_frac_b, cfg_frac_c, cfg_int_c, cfg_round, cfg_sat,
    output in_valid, a, b, out_ready, cnt_clr,
    input  cfg_ready, in_ready, out_valid, c, c_ovf, ovf_cnt
  );

  modport slave (
    input  cfg_valid, cfg_frac_a, cfg_frac_b, cfg_frac_c, cfg_int_c, cfg_round, cfg_sat,
    input  in_valid, a, b, out_ready, cnt_clr,
    output cfg_ready, in_ready, out_valid, c, c_ovf, ovf_cnt
  );
endinterface

// File: rtl/wlo_quant_mult_quantiser.sv
// -----------------------------------------------------------------------------
// wlo_quantiser
// Combinational fixed-point quantiser. Drops FRAC-frac low bits (truncate or
// round-half-up), then range-checks against a signed width of
// int_bits+FRAC and either saturates to the grid or wraps.
//   data_in  : signed input, FRAC fraction bits
//   frac     : fraction bits kept (must be <= FRAC)
//   int_bits : integer bits incl. sign of the checked range
//   round    : 1 = round-half-up, 0 = truncate
//   sat      : 1 = saturate on overflow, 0 = wrap
//   data_out : quantised value, same format as data_in
//   ovf      : the rounded value did not fit the checked range
// -----------------------------------------------------------------------------
module wlo_quantiser #(
  parameter int W    = 14,
  parameter int FRAC = 12
) (
  input  logic signed [W-1:0] data_in,
  input  logic [7:0]          frac,
  input  logic [7:0]          int_bits,
  input  logic                round,
  input  logic                sat,
  output logic signed [W-1:0] data_out,
  output logic                ovf
);

  // Two guard bits: one absorbs the rounding carry, one keeps the range
  // limits representable as signed values.
  localparam int EW = W + 2;
  localparam logic [7:0] FRAC_B = 8'(FRAC);
  localparam logic [7:0] EW_B   = 8'(EW);

  logic [7:0]           d;
  logic [7:0]           n;
  logic [7:0]           sh;
  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] bias;
  logic signed [EW-1:0] mask;
  logic signed [EW-1:0] q;
  logic signed [EW-1:0] hi;
  logic signed [EW-1:0] lo;
  logic signed [EW-1:0] grid_max;
  logic signed [EW-1:0] wrapped;
  logic signed [EW-1:0] res;

  always_comb begin
    d    = FRAC_B - frac;
    n    = int_bits + FRAC_B;
    sh   = EW_B - n;
    ext  = EW'(data_in);
    bias = '0;
    if (round && (d != 8'd0)) bias = EW'(1) <<< (d - 8'd1);
    mask = {EW{1'b1}} << d;
    q    = (ext + bias) & mask;

    hi       = (EW'(1) <<< (n - 8'd1)) - EW'(1);
    lo       = -(EW'(1) <<< (n - 8'd1));
    grid_max = hi & mask;
    // Keep the low n bits and sign-extend from bit n-1.
    wrapped  = (q <<< sh) >>> sh;

    ovf = (q > hi) || (q < lo);
    res = q;
    if (ovf) res = sat ? ((q > hi) ? grid_max : lo) : wrapped;
    data_out = res[W-1:0];
  end

endmodule

// File: rtl/wlo_quant_mult.sv
// -----------------------------------------------------------------------------
// wlo_quant_mult
// Three-stage pipelined signed multiplier with runtime quantisation:
//   S1 quantise a and b, S2 full-precision multiply, S3 quantise product.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : wlo_quant_mult_if slave (config, operands, product, stats)
// Config is only taken while the pipeline is empty and no operand is
// offered, so every sample is processed under a single configuration.
// One global stall: all stages advance together whenever the output
// register is empty or being read.
// -----------------------------------------------------------------------------
module wlo_quant_mult
  import wlo_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int IN_FRAC  = DEF_IN_FRAC,
  parameter int OUT_W    = 2 * IN_W + 1,
  parameter int OUT_FRAC = 2 * IN_FRAC,
  parameter int CNT_W    = DEF_CNT_W
) (
  input logic             clk,
  input logic             rstn,
  wlo_quant_mult_if.slave bus
);

  localparam logic [7:0] IN_FRAC_B   = 8'(IN_FRAC);
  localparam logic [7:0] OUT_FRAC_B  = 8'(OUT_FRAC);
  localparam logic [7:0] INT_C_MAX_B = 8'(OUT_W - OUT_FRAC);
  localparam logic [7:0] OP_INT_B    = 8'(IN_W - IN_FRAC);
  localparam wlo_cfg_t   CFG_RST     = default_cfg(IN_FRAC, OUT_W, OUT_FRAC);

  wlo_cfg_t                cfg_q;
  logic                    advance;
  logic                    cfg_load;
  logic                    accept;
  logic                    fire;
  logic                    cfg_round_up;

  logic                    v1, v2, v3;
  logic signed [IN_W-1:0]  qa, qb, a1, b1;
  logic                    ovf_a, ovf_b, ovf_c;
  logic                    ovf1, ovf2;
  logic signed [OUT_W-1:0] p2, qc, c_q;
  logic                    c_ovf_q;
  logic [CNT_W-1:0]        cnt_q;

  assign advance      = !v3 || bus.out_ready;
  assign bus.cfg_ready = !v1 && !v2 && !v3 && !bus.in_valid;
  assign cfg_load     = bus.cfg_valid && bus.cfg_ready;
  assign bus.in_ready = advance && !cfg_load;
  assign accept       = bus.in_valid && bus.in_ready;
  assign fire         = v3 && bus.out_ready && c_ovf_q;
  assign cfg_round_up = (cfg_q.round == RND_HALF_UP);

  assign bus.out_valid = v3;
  assign bus.c         = c_q;
  assign bus.c_ovf     = c_ovf_q;
  assign bus.ovf_cnt   = cnt_q;

  // Active configuration; out-of-range fields are clamped as they load.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cfg_q <= CFG_RST;
    end else if (cfg_load) begin
      cfg_q.frac_a <= clamp_u8(bus.cfg_frac_a, 8'd0, IN_FRAC_B);
      cfg_q.frac_b <= clamp_u8(bus.cfg_frac_b, 8'd0, IN_FRAC_B);
      cfg_q.frac_c <= clamp_u8(bus.cfg_frac_c, 8'd0, OUT_FRAC_B);
      cfg_q.int_c  <= clamp_u8(bus.cfg_int_c, 8'd1, INT_C_MAX_B);
      cfg_q.round  <= round_mode_e'(bus.cfg_round);
      cfg_q.sat    <= bus.cfg_sat;
    end
  end

  wlo_quantiser #(.W(IN_W), .FRAC(IN_FRAC)) u_quant_a (
    .data_in  (bus.a),
    .frac     (cfg_q.frac_a),
    .int_bits (OP_INT_B),
    .round    (cfg_round_up),
    .sat      (cfg_q.sat),
    .data_out (qa),
    .ovf      (ovf_a)
  );

  wlo_quantiser #(.W(IN_W), .FRAC(IN_FRAC)) u_quant_b (
    .data_in  (bus.b),
    .frac     (cfg_q.frac_b),
    .int_bits (OP_INT_B),
    .round    (cfg_round_up),
    .sat      (cfg_q.sat),
    .data_out (qb),
    .ovf      (ovf_b)
  );

  wlo_quantiser #(.W(OUT_W), .FRAC(OUT_FRAC)) u_quant_c (
    .data_in  (p2),
    .frac     (cfg_q.frac_c),
    .int_bits (cfg_q.int_c),
    .round    (cfg_round_up),
    .sat      (cfg_q.sat),
    .data_out (qc),
    .ovf      (ovf_c)
  );

  // Data registers only load behind a valid sample; bubbles leave them alone.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      a1      <= '0;
      b1      <= '0;
      ovf1    <= 1'b0;
      p2      <= '0;
      ovf2    <= 1'b0;
      c_q     <= '0;
      c_ovf_q <= 1'b0;
    end else if (advance) begin
      v1 <= accept;
      v2 <= v1;
      v3 <= v2;
      if (accept) begin
        a1   <= qa;
        b1   <= qb;
        ovf1 <= ovf_a || ovf_b;
      end
      if (v1) begin
        p2   <= OUT_W'(a1) * OUT_W'(b1);
        ovf2 <= ovf1;
      end
      if (v2) begin
        c_q     <= qc;
        c_ovf_q <= ovf2 || ovf_c;
      end
    end
  end

  // Saturating overflow statistics; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (fire && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: doc/wlo_quant_mult.md
Name: wlo_quant_mult

Overview:
- Next-generation word-length-optimisation datapath: a single fully parametrised, pipelined signed multiplier with runtime-programmable quantisation of both operands and the product.
- Adds runtime rounding mode, saturate/wrap selection, a programmable product integer width, valid/ready flow control, safe config shadowing and an overflow statistics counter.
- Sits between the WLO stimulus driver and the error-measurement logic; one instance per evaluated multiply node.

Parameters:
- IN_W, 14, operand width (signed two's complement).
- IN_FRAC, 12, binary-point position of operands (fraction bits at full precision).
- OUT_W, 2*IN_W+1, product width.
- OUT_FRAC, 2*IN_FRAC, binary-point position of product.
- CNT_W, 16, overflow counter width.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- cfg_valid  in  1  config load request.
- cfg_ready  out  1  pipeline empty; config may be applied.
- cfg_frac_a  in  8  fraction bits kept on a.
- cfg_frac_b  in  8  fraction bits kept on b.
- cfg_frac_c  in  8  fraction bits kept on product.
- cfg_int_c  in  8  product integer bits incl. sign.
- cfg_round  in  1  0 = truncate, 1 = round-half-up.
- cfg_sat  in  1  0 = wrap, 1 = saturate.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand accepted when high with in_valid.
- a  in  IN_W  operand a.
- b  in  IN_W  operand b.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accept.
- c  out  OUT_W  quantised product.
- c_ovf  out  1  overflow occurred on a, b or c for this sample.
- ovf_cnt  out  CNT_W  saturating count of samples with c_ovf.
- cnt_clr  in  1  synchronous clear of ovf_cnt.

Behaviour:
- Reset (async, rstn low):
  - all valid flags, c, c_ovf and ovf_cnt go to 0.
  - Active config resets to full precision: frac_a = frac_b = IN_FRAC, frac_c = OUT_FRAC, int_c = OUT_W-OUT_FRAC, round = 0, sat = 0.
  - Reset mid-operation drops all in-flight samples.
- Config:
  - Active config registers are loaded from cfg_* on a cycle where cfg_valid && cfg_ready.
  - cfg_ready = no stage valid && !in_valid.
  - While cfg_valid && cfg_ready, in_ready is forced low. Config always wins over a simultaneous operand.
  - Out-of-range values are clamped at load: frac_a/frac_b to IN_FRAC, frac_c to OUT_FRAC; int_c to the range 1..OUT_W-OUT_FRAC.
- Pipeline: 3 stages, S1 quantise a/b → S2 multiply → S3 quantise c.
  - Latency: 3 cycles from accept to out_valid. Throughput 1/cycle.
  - Global stall: advance = !out_valid || out_ready; in_ready = advance, except when config is being loaded.
  - c and c_ovf hold while out_valid && !out_ready.
- Quantiser (shared by all three):
  - d = FRAC - frac, i.e. the number of low bits to drop.
  - If d = 0, pass through unchanged.
  - Truncate: clear the low d bits (floor).
  - Round: add 2^(d-1), then clear the low d bits.
  - Range check:
    - Operands: the rounded result must fit IN_W bits signed.
    - Product: the result must fit signed in int_c+OUT_FRAC bits.
  - On overflow, sat=1 clamps to the grid maximum/minimum:
    - max = (2^(N-1)-1) with the low d bits cleared.
    - min = -2^(N-1).
    - N is the checked width.
  - On overflow, sat=0 wraps: keep the low N bits and sign-extend from bit N-1 to the full width.
- Multiply: full-precision signed product of the two IN_W operands, sign-extended to OUT_W.
- Overflow reporting and counter:
  - Overflow flags from S1 are pipelined alongside the data; c_ovf is the OR of the a, b and c overflow flags.
  - ovf_cnt increments on each out_valid && out_ready && c_ovf and saturates at all-ones.
  - cnt_clr has priority over an increment in the same cycle.

Decomposition:
- Package wlo_pkg holds:
  - round_mode_e (TRUNC, RND_HALF_UP).
  - Struct wlo_cfg_t with fields frac_a, frac_b, frac_c, int_c, round, sat.
  - Reset-default constants.
- Sub-module wlo_quantiser, parametrised by width W and FRAC:
  - Combinational.
  - Inputs: data, frac, int_bits, round, sat.
  - Outputs: data, ovf.
  - Instantiated three times.

Test Plan:
- Reset, cfg default, a=0x1800 (1.5), b=0x1000 (1.0) → after exactly 3 cycles c = 1.5·2^24 = 25165824, c_ovf = 0.
- cfg_frac_a=1, round=0, a=0x1400 (1.25), b=0x1000 → c = 1.0·2^24. Same with round=1 → c = 1.5·2^24.
- cfg_frac_a=0, round=1, a=0x1FFF, b=0x1000:
  - sat=1 → a quantised to 0x1000, c = 2^24, c_ovf = 1, ovf_cnt = 1.
  - sat=0 → a wraps to 0x2000 (-2.0), c = -2·2^24.
- cfg_int_c=2, a=b=0x2000 (-2.0), product 4.0:
  - sat=1 → c = 0x1FFFFFF.
  - sat=0 → c = 0, c_ovf = 1.
- Back-to-back stream of 10 operands with out_ready toggling 1/0 → no loss or duplication, order preserved.
- Stall handling: cfg_valid asserted while samples are in flight → cfg_ready is low until the pipeline drains; the new config applies only to later samples.
- Reset asserted mid-stream → outputs are 0 immediately.
- ovf_cnt forced to saturation → holds at all-ones on further overflows; cnt_clr together with an overflow → counter reads 0.
